pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Fetch-stage program counter and next-PC selection for the pipelined MIPS core.
- Consumes the ID-stage branch decision produced by CMP (CMP_o_Output) and the ID-stage control/operands, and redirects fetch.
- Branches and jumps resolve in ID with one architectural delay slot. The instruction already in IF is never flushed.
- Also raises a fetch address-error flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- PCU_i_Clk  input  1  clock; all state updates on rising edge.
- PCU_i_Reset  input  1  reset; synchronous, active-high.
- PCU_i_Stall  input  1  hazard-unit stall. 1 means hold PC and ignore the redirect.
- PCU_i_NPCOp  input  2  ID-stage next-PC op: 0 seq, 1 branch, 2 j/jal, 3 jr.
- PCU_i_BranchTaken  input  1  CMP_o_Output for the instruction in ID.
- PCU_i_IDPC  input  32  PC of the instruction in ID.
- PCU_i_Imm16  input  16  ID instr[15:0].
- PCU_i_Index26  input  26  ID instr[25:0].
- PCU_i_RsVal  input  32  forwarded rs value in ID (jr target).
- PCU_o_PC  output  32  current fetch address (registered).
- PCU_o_PCPlus8  output  32  PCU_i_IDPC+8, link value for jal/bgezal.
- PCU_o_Redirect  output  1  registered: 1 for the cycle after a taken redirect was committed.
- PCU_o_ExcAdEL  output  1  combinational: PC misaligned or outside [TEXT_LO, TEXT_HI].
- PCU_o_FetchCnt  output  32  count of PC advances since reset (performance counter).

Behaviour:
- Reset (sync, edge with PCU_i_Reset=1):
  - PC <= RESET_PC.
  - Redirect <= 0.
  - FetchCnt <= 0.
  - Reset wins over every other input, including mid-stall and mid-redirect.
- Target arithmetic, all 32-bit with wrap-around and no overflow detection:
  - seq = PC+4.
  - br = IDPC+4+(sign_ext(Imm16)<<2).
  - jmp = {(IDPC+4)[31:28], Index26, 2'b00}.
  - jr = RsVal, used unaltered with no masking.
- Next-PC priority when not in reset:
  - Stall=1: PC holds and FetchCnt holds. NPCOp and BranchTaken are ignored, because the branch is re-evaluated when ID releases. Redirect <= 0.
  - NPCOp=3: PC <= jr.
  - NPCOp=2: PC <= jmp.
  - NPCOp=1 and BranchTaken=1: PC <= br.
  - NPCOp=1 and BranchTaken=0: PC <= seq.
  - NPCOp=0: PC <= seq.
- Redirect <= 1 iff the PC was loaded from jr, jmp or taken br in that edge; otherwise 0. Latency is 1 cycle: a redirect decided in cycle N appears on PCU_o_PC in cycle N+1.
- Delay slot: the instruction fetched in the same cycle as the ID-stage branch (at IDPC+4) proceeds normally. pc_unit generates no flush.
- FetchCnt increments by 1 on every non-reset, non-stall edge and wraps from 32'hFFFFFFFF to 0.
- ExcAdEL = (PC[1:0]!=0) || PC<TEXT_LO || PC>TEXT_HI, computed from the registered PC.
  - The PC keeps advancing after an error; the exception handling belongs to CP0, not to this block.
- NPCOp values are exhaustive; there is no undefined encoding.
- A taken branch with a negative offset may move the PC below TEXT_LO. ExcAdEL then asserts and the PC is unchanged otherwise.

Test Plan:
- Reset for 1 cycle, then 3 edges with NPCOp=0 and Stall=0 -> PC=0x3000, 0x3004, 0x3008, 0x300C. FetchCnt=3. Redirect=0. ExcAdEL=0.
- IDPC=0x3004, NPCOp=1, Imm16=0x0003, BranchTaken=1 -> next PC=0x3014 and Redirect=1 for one cycle. Same stimulus with BranchTaken=0 -> PC=PC+4 and Redirect=0.
- IDPC=0x3010, NPCOp=1, Imm16=0xFFFC, BranchTaken=1 -> PC=0x3004. PCPlus8=0x3018.
- Stall=1 for 2 cycles with NPCOp=2 asserted -> PC and FetchCnt hold and Redirect=0. Release with IDPC=0x3000, Index26=0x0000C40 -> PC=0x00003100.
- NPCOp=3, RsVal=0x00003002 -> PC=0x3002 and ExcAdEL=1. Next seq edge -> PC=0x3006 and ExcAdEL stays 1. NPCOp=3 with RsVal=0x7000 -> ExcAdEL=1.
- Assert Reset in the same edge as NPCOp=3 and Stall=1 -> PC=0x3000, FetchCnt=0, Redirect=0.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with ID-stage next-PC selection (one delay slot).
// Also tracks PC advances and flags misaligned or out-of-text fetch addresses.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        PCU_i_Clk,
    input  logic        PCU_i_Reset,
    input  logic        PCU_i_Stall,
    input  logic [1:0]  PCU_i_NPCOp,
    input  logic        PCU_i_BranchTaken,
    input  logic [31:0] PCU_i_IDPC,
    input  logic [15:0] PCU_i_Imm16,
    input  logic [25:0] PCU_i_Index26,
    input  logic [31:0] PCU_i_RsVal,
    output logic [31:0] PCU_o_PC,
    output logic [31:0] PCU_o_PCPlus8,
    output logic        PCU_o_Redirect,
    output logic        PCU_o_ExcAdEL,
    output logic [31:0] PCU_o_FetchCnt
);

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    logic        [31:0] r_pc;
    logic               r_redirect;
    logic        [31:0] r_fetch_cnt;

    logic        [31:0] w_seq;
    logic        [31:0] w_idpc4;
    logic signed [31:0] w_br_off;
    logic        [31:0] w_br;
    logic        [31:0] w_jmp;
    logic        [31:0] w_next_pc;
    logic               w_take;

    assign w_seq    = r_pc + 32'd4;
    assign w_idpc4  = PCU_i_IDPC + 32'd4;
    assign w_br_off = signed'({{14{PCU_i_Imm16[15]}}, PCU_i_Imm16, 2'b00});
    assign w_br     = w_idpc4 + unsigned'(w_br_off);
    assign w_jmp    = {w_idpc4[31:28], PCU_i_Index26, 2'b00};

    // Non-sequential targets are what raise the redirect flag on the next cycle.
    always_comb begin
        w_next_pc = w_seq;
        w_take    = 1'b0;
        case (PCU_i_NPCOp)
            NPC_JR: begin
                w_next_pc = PCU_i_RsVal;
                w_take    = 1'b1;
            end
            NPC_J: begin
                w_next_pc = w_jmp;
                w_take    = 1'b1;
            end
            NPC_BR: begin
                if (PCU_i_BranchTaken) begin
                    w_next_pc = w_br;
                    w_take    = 1'b1;
                end
            end
            NPC_SEQ: begin
                w_next_pc = w_seq;
            end
            default: begin
                w_next_pc = w_seq;
            end
        endcase
    end

    always_ff @(posedge PCU_i_Clk) begin
        if (PCU_i_Reset) begin
            r_pc        <= RESET_PC;
            r_redirect  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else if (PCU_i_Stall) begin
            r_redirect  <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_redirect  <= w_take;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign PCU_o_PC       = r_pc;
    assign PCU_o_PCPlus8  = PCU_i_IDPC + 32'd8;
    assign PCU_o_Redirect = r_redirect;
    assign PCU_o_FetchCnt = r_fetch_cnt;
    assign PCU_o_ExcAdEL  = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit: each record is one clock edge of
// stimulus with the PC, redirect, address-error, counter and link values expected after it.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  npcop;
    logic        taken;
    logic [31:0] idpc;
    logic [15:0] imm16;
    logic [25:0] idx26;
    logic [31:0] rsval;
    logic [31:0] pc;
    logic [31:0] pcplus8;
    logic        redirect;
    logic        exc;
    logic [31:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  npcop;
        logic        taken;
        logic [31:0] idpc;
        logic [15:0] imm16;
        logic [25:0] idx26;
        logic [31:0] rsval;
        logic [31:0] exp_pc;
        logic        exp_red;
        logic        exp_exc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    pc_unit dut (
        .PCU_i_Clk         (clk),
        .PCU_i_Reset       (rst),
        .PCU_i_Stall       (stall),
        .PCU_i_NPCOp       (npcop),
        .PCU_i_BranchTaken (taken),
        .PCU_i_IDPC        (idpc),
        .PCU_i_Imm16       (imm16),
        .PCU_i_Index26     (idx26),
        .PCU_i_RsVal       (rsval),
        .PCU_o_PC          (pc),
        .PCU_o_PCPlus8     (pcplus8),
        .PCU_o_Redirect    (redirect),
        .PCU_o_ExcAdEL     (exc),
        .PCU_o_FetchCnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [1:0] op, input logic t,
                       input logic [31:0] ip, input logic [15:0] im, input logic [25:0] ix,
                       input logic [31:0] rv, input logic [31:0] epc, input logic ered,
                       input logic eexc, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.stall = s; v.npcop = op; v.taken = t;
        v.idpc = ip; v.imm16 = im; v.idx26 = ix; v.rsval = rv;
        v.exp_pc = epc; v.exp_red = ered; v.exp_exc = eexc; v.exp_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] op, input logic t,
                         input logic [31:0] ip, input logic [15:0] im, input logic [25:0] ix,
                         input logic [31:0] rv);
        @(negedge clk);
        rst = r; stall = s; npcop = op; taken = t;
        idpc = ip; imm16 = im; idx26 = ix; rsval = rv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; npcop = 2'd0; taken = 1'b0;
        idpc = 32'd0; imm16 = 16'd0; idx26 = 26'd0; rsval = 32'd0;

        //   rst  stl op  tk  idpc          imm       idx          rs            exp_pc        red  exc  cnt
        add(1'b1,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_3000,1'b0,1'b0,32'd0);
        add(1'b0,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_3004,1'b0,1'b0,32'd1);
        add(1'b0,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_3008,1'b0,1'b0,32'd2);
        add(1'b0,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_300C,1'b0,1'b0,32'd3);
        add(1'b0,1'b0,2'd1,1'b1,32'h0000_3004,16'h0003, 26'h0,       32'h0,        32'h0000_3014,1'b1,1'b0,32'd4);
        add(1'b0,1'b0,2'd1,1'b0,32'h0000_3004,16'h0003, 26'h0,       32'h0,        32'h0000_3018,1'b0,1'b0,32'd5);
        add(1'b0,1'b0,2'd1,1'b1,32'h0000_3010,16'hFFFC, 26'h0,       32'h0,        32'h0000_3004,1'b1,1'b0,32'd6);
        add(1'b0,1'b1,2'd2,1'b0,32'h0000_3000,16'h0,    26'h0000C40, 32'h0,        32'h0000_3004,1'b0,1'b0,32'd6);
        add(1'b0,1'b1,2'd2,1'b0,32'h0000_3000,16'h0,    26'h0000C40, 32'h0,        32'h0000_3004,1'b0,1'b0,32'd6);
        add(1'b0,1'b0,2'd2,1'b0,32'h0000_3000,16'h0,    26'h0000C40, 32'h0,        32'h0000_3100,1'b1,1'b0,32'd7);
        add(1'b0,1'b0,2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_3002,32'h0000_3002,1'b1,1'b1,32'd8);
        add(1'b0,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_3006,1'b0,1'b1,32'd9);
        add(1'b0,1'b0,2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_7000,32'h0000_7000,1'b1,1'b1,32'd10);
        add(1'b0,1'b0,2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_6FFC,32'h0000_6FFC,1'b1,1'b0,32'd11);
        add(1'b0,1'b0,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,        32'h0000_7000,1'b0,1'b1,32'd12);
        add(1'b0,1'b0,2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_2FFC,32'h0000_2FFC,1'b1,1'b1,32'd13);
        add(1'b0,1'b0,2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_3000,32'h0000_3000,1'b1,1'b0,32'd14);
        add(1'b1,1'b1,2'd3,1'b1,32'h0,        16'h0,    26'h0,       32'h0000_5000,32'h0000_3000,1'b0,1'b0,32'd0);
        add(1'b0,1'b0,2'd2,1'b0,32'hF000_0000,16'h0,    26'h0,       32'h0,        32'hF000_0000,1'b1,1'b1,32'd1);
        add(1'b0,1'b0,2'd1,1'b0,32'h0000_3000,16'h8000, 26'h0,       32'h0,        32'hF000_0004,1'b0,1'b1,32'd2);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].npcop, vecs[i].taken,
                  vecs[i].idpc, vecs[i].imm16, vecs[i].idx26, vecs[i].rsval);
            chk("pc",       i, pc,                 vecs[i].exp_pc);
            chk("redirect", i, {31'd0, redirect},  {31'd0, vecs[i].exp_red});
            chk("adel",     i, {31'd0, exc},       {31'd0, vecs[i].exp_exc});
            chk("fetchcnt", i, cnt,                vecs[i].exp_cnt);
            chk("pcplus8",  i, pcplus8,            vecs[i].idpc + 32'd8);
        end

        // Branch target wrapping past 2^32; then a stall clears the redirect.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        drive(1'b0, 1'b0, 2'd1, 1'b1, 32'hFFFF_FFFC, 16'h0001, 26'h0, 32'h0);
        chk("wrap_pc",    100, pc,                32'h0000_0004);
        chk("wrap_red",   100, {31'd0, redirect}, 32'd1);
        chk("wrap_adel",  100, {31'd0, exc},      32'd1);
        chk("wrap_link",  100, pcplus8,           32'h0000_0004);
        drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_4000);
        chk("stall_pc",   101, pc,                32'h0000_0004);
        chk("stall_red",  101, {31'd0, redirect}, 32'd0);
        chk("stall_cnt",  101, cnt,               32'd1);

        // Back-to-back redirects keep the flag high; reset during a stall restores the start state.
        drive(1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_4000);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_3FFC, 16'h0, 26'h0000010, 32'h0);
        chk("b2b_pc",     102, pc,                32'h0000_0040);
        chk("b2b_red",    102, {31'd0, redirect}, 32'd1);
        chk("b2b_cnt",    102, cnt,               32'd3);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
        chk("rst_pc",     103, pc,                32'h0000_3000);
        chk("rst_cnt",    103, cnt,               32'd0);
        chk("rst_adel",   103, {31'd0, exc},      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
